// File: rtl/wb_pkg.sv
// Shared definitions for the register-file writeback arbiter: parameter
// defaults, the zero-register constant and a packed-bus address extractor.
package wb_pkg;

    localparam int NREQ_DEF   = 4;
    localparam int AW_DEF     = 5;
    localparam int DW_DEF     = 32;

    // Register 0 is hard-wired; writes to it are acknowledged but dropped.
    localparam int REG_ZERO   = 0;

    // Upper bounds used by the extractor so it can serve any legal AW/NREQ.
    localparam int MAX_NREQ   = 8;
    localparam int ADDR_MAXW  = 16;
    localparam int ADDR_BUS_W = MAX_NREQ * ADDR_MAXW;

    // Returns requester idx's address from a zero-extended packed bus whose
    // fields are aw bits wide.
    function automatic logic [ADDR_MAXW-1:0] req_addr_of(
        input logic [ADDR_BUS_W-1:0] bus,
        input int unsigned           idx,
        input int unsigned           aw
    );
        logic [ADDR_BUS_W-1:0] shifted;
        logic [ADDR_MAXW-1:0]  field_mask;
        shifted    = bus >> (idx * aw);
        field_mask = (ADDR_MAXW'(1) << aw) - ADDR_MAXW'(1);
        return shifted[ADDR_MAXW-1:0] & field_mask;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Rotating find-first-set: returns the first set bit of mask_i when scanning
// start_i, start_i+1, ... modulo N.
module rr_pick #(
    parameter int N  = 4,
    parameter int IW = 2
) (
    input  logic [N-1:0]  mask_i,
    input  logic [IW-1:0] start_i,
    output logic          found_o,
    output logic [IW-1:0] idx_o
);

    logic [IW-1:0] pos;

    // Walk the ring once from the start pointer; first hit wins.
    always_comb begin
        found_o = 1'b0;
        idx_o   = '0;
        pos     = '0;
        for (int k = 0; k < N; k++) begin
            pos = IW'((int'(start_i) + k) % N);
            if (!found_o && mask_i[pos]) begin
                found_o = 1'b1;
                idx_o   = pos;
            end
        end
    end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Schedules up to two register-file writebacks per cycle from NREQ requesters
// with rotating priority. Same-address writes are never paired in one cycle,
// and zero-register writes are acknowledged without using a port.
module regfile_wb_arbiter
    import wb_pkg::*;
#(
    parameter int NREQ = NREQ_DEF,
    parameter int AW   = AW_DEF,
    parameter int DW   = DW_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NREQ-1:0]    req_valid,
    input  logic [NREQ*AW-1:0] req_addr,
    input  logic [NREQ*DW-1:0] req_data,
    output logic [NREQ-1:0]    req_ready,
    output logic               wen0,
    output logic [AW-1:0]      waddr0,
    output logic [DW-1:0]      wdata0,
    output logic               wen1,
    output logic [AW-1:0]      waddr1,
    output logic [DW-1:0]      wdata1,
    output logic [1:0]         grant_count
);

    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [ADDR_BUS_W-1:0] addr_bus_ext;
    logic [AW-1:0]         addr_w [NREQ];
    logic [DW-1:0]         data_w [NREQ];
    logic [NREQ-1:0]       nz_valid;
    logic [NREQ-1:0]       b_mask;

    logic                  a_found, b_found;
    logic [IW-1:0]         a_idx, b_idx, b_start;

    logic [IW-1:0]         rr_ptr_q, rr_ptr_d;
    logic                  wen0_q, wen1_q;
    logic [AW-1:0]         waddr0_q, waddr1_q;
    logic [DW-1:0]         wdata0_q, wdata1_q;
    logic [1:0]            grant_count_q, grant_count_d;

    assign addr_bus_ext = ADDR_BUS_W'(req_addr);

    // Unpack the buses and classify each request.
    for (genvar gi = 0; gi < NREQ; gi++) begin : g_req
        assign addr_w[gi]   = AW'(req_addr_of(addr_bus_ext, gi, AW));
        assign data_w[gi]   = req_data[gi*DW +: DW];
        assign nz_valid[gi] = req_valid[gi] && (addr_w[gi] != AW'(REG_ZERO));
        // B candidates exclude A itself and anything targeting A's register.
        assign b_mask[gi]   = nz_valid[gi] && (IW'(gi) != a_idx)
                              && (addr_w[gi] != addr_w[a_idx]);
        // Zero-register writes are always accepted; others only when picked.
        assign req_ready[gi] = !rst && req_valid[gi]
                               && ((addr_w[gi] == AW'(REG_ZERO))
                                   || (a_found && (a_idx == IW'(gi)))
                                   || (b_found && (b_idx == IW'(gi))));
    end

    rr_pick #(.N(NREQ), .IW(IW)) u_pick_a (
        .mask_i  (nz_valid),
        .start_i (rr_ptr_q),
        .found_o (a_found),
        .idx_o   (a_idx)
    );

    assign b_start = (a_idx == IW'(NREQ-1)) ? '0 : a_idx + 1'b1;

    rr_pick #(.N(NREQ), .IW(IW)) u_pick_b (
        .mask_i  (b_mask),
        .start_i (b_start),
        .found_o (b_found),
        .idx_o   (b_idx)
    );

    // Pointer moves past the last granted requester; port count for this cycle.
    always_comb begin
        rr_ptr_d      = rr_ptr_q;
        grant_count_d = {1'b0, a_found} + {1'b0, b_found};
        if (b_found) begin
            rr_ptr_d = (b_idx == IW'(NREQ-1)) ? '0 : b_idx + 1'b1;
        end else if (a_found) begin
            rr_ptr_d = b_start;
        end
    end

    // Register the write stream; data/address only load on a grant.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr_q      <= '0;
            wen0_q        <= 1'b0;
            wen1_q        <= 1'b0;
            waddr0_q      <= '0;
            waddr1_q      <= '0;
            wdata0_q      <= '0;
            wdata1_q      <= '0;
            grant_count_q <= '0;
        end else begin
            rr_ptr_q      <= rr_ptr_d;
            wen0_q        <= a_found;
            wen1_q        <= b_found;
            grant_count_q <= grant_count_d;
            if (a_found) begin
                waddr0_q <= addr_w[a_idx];
                wdata0_q <= data_w[a_idx];
            end
            if (b_found) begin
                waddr1_q <= addr_w[b_idx];
                wdata1_q <= data_w[b_idx];
            end
        end
    end

    assign wen0        = wen0_q;
    assign waddr0      = waddr0_q;
    assign wdata0      = wdata0_q;
    assign wen1        = wen1_q;
    assign waddr1      = waddr1_q;
    assign wdata1      = wdata1_q;
    assign grant_count = grant_count_q;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter with hand-computed expectations.
module tb_regfile_wb_arbiter;

    logic         clk;
    logic         rst;
    logic [3:0]   req_valid;
    logic [19:0]  req_addr;
    logic [127:0] req_data;
    logic [3:0]   req_ready;
    logic         wen0, wen1;
    logic [4:0]   waddr0, waddr1;
    logic [31:0]  wdata0, wdata1;
    logic [1:0]   grant_count;

    int n_cmp = 0;
    int n_bad = 0;

    regfile_wb_arbiter #(.NREQ(4), .AW(5), .DW(32)) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_addr    (req_addr),
        .req_data    (req_data),
        .req_ready   (req_ready),
        .wen0        (wen0),
        .waddr0      (waddr0),
        .wdata0      (wdata0),
        .wen1        (wen1),
        .waddr1      (waddr1),
        .wdata1      (wdata1),
        .grant_count (grant_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #50000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [19:0] pa(input logic [4:0] a3, input logic [4:0] a2,
                                       input logic [4:0] a1, input logic [4:0] a0);
        return {a3, a2, a1, a0};
    endfunction

    function automatic logic [127:0] pd(input logic [31:0] d3, input logic [31:0] d2,
                                        input logic [31:0] d1, input logic [31:0] d0);
        return {d3, d2, d1, d0};
    endfunction

    // Called at a falling edge; leaves the bench at the next falling edge.
    task automatic step(input string tag, input logic [3:0] v, input logic [19:0] a,
                        input logic [127:0] d, input logic [3:0] e_rdy,
                        input logic e_w0, input logic [4:0] e_a0, input logic [31:0] e_d0,
                        input logic e_w1, input logic [4:0] e_a1, input logic [31:0] e_d1,
                        input logic [1:0] e_gc);
        req_valid = v;
        req_addr  = a;
        req_data  = d;
        #1;
        chk({tag, ".ready"}, 64'(req_ready), 64'(e_rdy));
        @(posedge clk);
        #1;
        chk({tag, ".wen0"}, 64'(wen0), 64'(e_w0));
        if (e_w0) begin
            chk({tag, ".waddr0"}, 64'(waddr0), 64'(e_a0));
            chk({tag, ".wdata0"}, 64'(wdata0), 64'(e_d0));
        end
        chk({tag, ".wen1"}, 64'(wen1), 64'(e_w1));
        if (e_w1) begin
            chk({tag, ".waddr1"}, 64'(waddr1), 64'(e_a1));
            chk({tag, ".wdata1"}, 64'(wdata1), 64'(e_d1));
        end
        chk({tag, ".gcount"}, 64'(grant_count), 64'(e_gc));
        $display("txn %s: valid=%b ready=%b wen0=%b a0=%0d d0=%h wen1=%b a1=%0d d1=%h gc=%0d",
                 tag, v, req_ready, wen0, waddr0, wdata0, wen1, waddr1, wdata1, grant_count);
        @(negedge clk);
    endtask

    task automatic do_reset();
        req_valid = 4'b0000;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        int cnt [4];

        // Reset state, with requests present to prove ready is held low.
        rst       = 1'b1;
        req_valid = 4'b1111;
        req_addr  = pa(5'd6, 5'd5, 5'd4, 5'd3);
        req_data  = '0;
        #1;
        chk("rst.ready", 64'(req_ready), 64'd0);
        @(posedge clk);
        #1;
        chk("rst.wen0", 64'(wen0), 64'd0);
        chk("rst.wen1", 64'(wen1), 64'd0);
        chk("rst.waddr0", 64'(waddr0), 64'd0);
        chk("rst.wdata0", 64'(wdata0), 64'd0);
        chk("rst.gcount", 64'(grant_count), 64'd0);
        @(negedge clk);
        rst       = 1'b0;
        req_valid = 4'b0000;

        step("single", 4'b0001, pa(5'd0, 5'd0, 5'd0, 5'd7), pd(0, 0, 0, 32'hDEADBEEF),
             4'b0001, 1'b1, 5'd7, 32'hDEADBEEF, 1'b0, 5'd0, 32'd0, 2'd1);

        do_reset();
        step("dual1", 4'b1111, pa(5'd6, 5'd5, 5'd4, 5'd3),
             pd(32'hA3, 32'hA2, 32'hA1, 32'hA0),
             4'b0011, 1'b1, 5'd3, 32'hA0, 1'b1, 5'd4, 32'hA1, 2'd2);
        step("dual2", 4'b1100, pa(5'd6, 5'd5, 5'd4, 5'd3),
             pd(32'hA3, 32'hA2, 32'hA1, 32'hA0),
             4'b1100, 1'b1, 5'd5, 32'hA2, 1'b1, 5'd6, 32'hA3, 2'd2);
        // Pointer back at 0: requester 1 must land on port 0.
        step("rr_wrap", 4'b0110, pa(5'd0, 5'd5, 5'd4, 5'd0),
             pd(0, 32'hB2, 32'hB1, 0),
             4'b0110, 1'b1, 5'd4, 32'hB1, 1'b1, 5'd5, 32'hB2, 2'd2);
        // Pointer now 3; both target r9.
        step("coll1", 4'b0011, pa(5'd0, 5'd0, 5'd9, 5'd9), pd(0, 0, 32'h22, 32'h11),
             4'b0001, 1'b1, 5'd9, 32'h11, 1'b0, 5'd0, 32'd0, 2'd1);
        step("coll2", 4'b0010, pa(5'd0, 5'd0, 5'd9, 5'd9), pd(0, 0, 32'h22, 32'h11),
             4'b0010, 1'b1, 5'd9, 32'h22, 1'b0, 5'd0, 32'd0, 2'd1);
        // Pointer now 2.
        step("zero", 4'b0101, pa(5'd0, 5'd12, 5'd0, 5'd0), pd(0, 32'hC, 0, 32'h55),
             4'b0101, 1'b1, 5'd12, 32'hC, 1'b0, 5'd0, 32'd0, 2'd1);
        // Pointer now 3; idle and zero-only cycles leave it there.
        step("idle", 4'b0000, pa(5'd0, 5'd0, 5'd0, 5'd0), pd(0, 0, 0, 0),
             4'b0000, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 2'd0);
        step("zonly", 4'b0001, pa(5'd0, 5'd0, 5'd0, 5'd0), pd(0, 0, 0, 32'h77),
             4'b0001, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 2'd0);
        step("rr_hold", 4'b1001, pa(5'd2, 5'd0, 5'd0, 5'd1), pd(32'hD3, 0, 0, 32'hD0),
             4'b1001, 1'b1, 5'd2, 32'hD3, 1'b1, 5'd1, 32'hD0, 2'd2);
        // Pointer now 1; requester 0 collides with A and is skipped.
        step("skip1", 4'b0111, pa(5'd0, 5'd10, 5'd8, 5'd8),
             pd(0, 32'hE2, 32'hE1, 32'hE0),
             4'b0110, 1'b1, 5'd8, 32'hE1, 1'b1, 5'd10, 32'hE2, 2'd2);
        step("skip2", 4'b0001, pa(5'd0, 5'd10, 5'd8, 5'd8),
             pd(0, 32'hE2, 32'hE1, 32'hE0),
             4'b0001, 1'b1, 5'd8, 32'hE0, 1'b0, 5'd0, 32'd0, 2'd1);

        // Fairness: all four held valid for 8 cycles.
        do_reset();
        for (int i = 0; i < 4; i++) cnt[i] = 0;
        req_valid = 4'b1111;
        req_addr  = pa(5'd6, 5'd5, 5'd4, 5'd3);
        req_data  = pd(32'hF3, 32'hF2, 32'hF1, 32'hF0);
        for (int c = 0; c < 8; c++) begin
            #1;
            for (int i = 0; i < 4; i++) cnt[i] += int'(req_ready[i]);
            @(posedge clk);
            #1;
            chk($sformatf("fair%0d.gcount", c), 64'(grant_count), 64'd2);
            $display("txn fair%0d: ready=%b gc=%0d", c, req_ready, grant_count);
            @(negedge clk);
        end
        for (int i = 0; i < 4; i++)
            chk($sformatf("fair.count%0d", i), 64'(cnt[i]), 64'd4);

        // Asynchronous reset while both ports are writing.
        @(posedge clk);
        #1;
        chk("arst.pre_wen0", 64'(wen0), 64'd1);
        chk("arst.pre_wen1", 64'(wen1), 64'd1);
        #2;
        rst = 1'b1;
        #1;
        chk("arst.wen0", 64'(wen0), 64'd0);
        chk("arst.wen1", 64'(wen1), 64'd0);
        chk("arst.ready", 64'(req_ready), 64'd0);
        chk("arst.gcount", 64'(grant_count), 64'd0);
        $display("txn arst: ready=%b wen0=%b wen1=%b", req_ready, wen0, wen1);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("arst.post_ready", 64'(req_ready), 64'b0011);
        @(posedge clk);
        #1;
        chk("arst.post_waddr0", 64'(waddr0), 64'd3);
        chk("arst.post_waddr1", 64'(waddr1), 64'd4);
        $display("txn arst_post: wen0=%b a0=%0d wen1=%b a1=%0d", wen0, waddr0, wen1, waddr1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
